// File: rtl/fake_n64_pkg.sv
// Shared types and command constants for the fake N64 link sequencer.
// Holds the sequencer state encodings and the supported-command filter.
package fake_n64_pkg;

  typedef enum logic [1:0] {
    ST_LISTEN     = 2'b00,
    ST_TURNAROUND = 2'b01,
    ST_TX         = 2'b10,
    ST_RECOVER    = 2'b11
  } seq_state_t;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  // READ/WRITE are decoded by the receiver but this controller has no pak to answer them.
  function automatic logic cmd_supported(input logic [7:0] cmd_byte);
    logic ok;
    case (cmd_byte)
      CMD_INFO, CMD_STATUS, CMD_RESET: ok = 1'b1;
      CMD_READ, CMD_WRITE:             ok = 1'b0;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fake_n64_cycle_timer.sv
// Loadable down-counter; load takes effect on the next edge, then counts down to 0 and holds.
// expired is combinational from the count register, so it is high for the whole cycle the count is 0.
module fake_n64_cycle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             sample_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/fake_n64_link_sequencer.sv
// Half-duplex link sequencer: LISTEN -> TURNAROUND -> TX -> RECOVER, one shared phase timer.
// No backpressure; commands arriving outside LISTEN are silently ignored.
module fake_n64_link_sequencer
  import fake_n64_pkg::*;
#(
  parameter int TURNAROUND_CYCLES = 8,
  parameter int TX_TIMEOUT        = 512,
  parameter int RECOVER_CYCLES    = 16
) (
  input  logic       sample_clk,
  input  logic       reset,
  input  logic       rx_cmd_valid,
  input  logic [7:0] rx_cmd,
  input  logic       tx_handoff,
  output logic       cur_operation,
  output logic [7:0] cmd,
  output logic [1:0] seq_state,
  output logic [7:0] resp_count,
  output logic [7:0] drop_count,
  output logic [3:0] timeout_count
);

  localparam int TA_LOAD   = TURNAROUND_CYCLES - 1;
  localparam int TX_LOAD   = TX_TIMEOUT - 1;
  localparam int RC_LOAD   = RECOVER_CYCLES - 1;
  localparam int MAX_AB    = (TA_LOAD > TX_LOAD) ? TA_LOAD : TX_LOAD;
  localparam int TIMER_MAX = (MAX_AB > RC_LOAD) ? MAX_AB : RC_LOAD;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  seq_state_t         state_q, state_d;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_value;
  logic               timer_expired;
  logic               handoff_q;
  logic               handoff_edge;
  logic               accept_cmd;
  logic               drop_cmd;
  logic               resp_inc;
  logic               timeout_inc;

  fake_n64_cycle_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .sample_clk (sample_clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .expired    (timer_expired)
  );

  assign handoff_edge = (tx_handoff != handoff_q);

  always_comb begin
    state_d          = state_q;
    timer_load       = 1'b0;
    timer_load_value = '0;
    accept_cmd       = 1'b0;
    drop_cmd         = 1'b0;
    resp_inc         = 1'b0;
    timeout_inc      = 1'b0;
    case (state_q)
      ST_LISTEN: begin
        if (rx_cmd_valid) begin
          if (cmd_supported(rx_cmd)) begin
            accept_cmd       = 1'b1;
            timer_load       = 1'b1;
            timer_load_value = TIMER_W'(TA_LOAD);
            state_d          = ST_TURNAROUND;
          end else begin
            drop_cmd = 1'b1;
          end
        end
      end
      ST_TURNAROUND: begin
        if (timer_expired) begin
          timer_load       = 1'b1;
          timer_load_value = TIMER_W'(TX_LOAD);
          state_d          = ST_TX;
        end
      end
      ST_TX: begin
        // A handoff landing on the watchdog's last cycle still counts as a real response.
        if (handoff_edge) begin
          resp_inc         = 1'b1;
          timer_load       = 1'b1;
          timer_load_value = TIMER_W'(RC_LOAD);
          state_d          = ST_RECOVER;
        end else if (timer_expired) begin
          timeout_inc      = 1'b1;
          timer_load       = 1'b1;
          timer_load_value = TIMER_W'(RC_LOAD);
          state_d          = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (timer_expired) begin
          state_d = ST_LISTEN;
        end
      end
      default: state_d = ST_LISTEN;
    endcase
  end

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q       <= ST_LISTEN;
      handoff_q     <= tx_handoff;
      cmd           <= 8'h00;
      resp_count    <= 8'd0;
      drop_count    <= 8'd0;
      timeout_count <= 4'd0;
    end else begin
      state_q   <= state_d;
      handoff_q <= tx_handoff;
      if (accept_cmd) begin
        cmd <= rx_cmd;
      end
      if (resp_inc) begin
        resp_count <= resp_count + 8'd1;
      end
      if (drop_cmd && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
      if (timeout_inc && (timeout_count != 4'hF)) begin
        timeout_count <= timeout_count + 4'd1;
      end
    end
  end

  assign cur_operation = (state_q == ST_TX);
  assign seq_state     = state_q;

endmodule

// File: tb/tb_fake_n64_link_sequencer.sv
// Directed bench for the link sequencer: a LISTEN command table plus timing and corner sequences.
module tb_fake_n64_link_sequencer;

  logic       sample_clk;
  logic       reset;
  logic       rx_cmd_valid;
  logic [7:0] rx_cmd;
  logic       tx_handoff;
  logic       cur_operation;
  logic [7:0] cmd;
  logic [1:0] seq_state;
  logic [7:0] resp_count;
  logic [7:0] drop_count;
  logic [3:0] timeout_count;

  int checks   = 0;
  int failures = 0;

  fake_n64_link_sequencer dut (
    .sample_clk    (sample_clk),
    .reset         (reset),
    .rx_cmd_valid  (rx_cmd_valid),
    .rx_cmd        (rx_cmd),
    .tx_handoff    (tx_handoff),
    .cur_operation (cur_operation),
    .cmd           (cmd),
    .seq_state     (seq_state),
    .resp_count    (resp_count),
    .drop_count    (drop_count),
    .timeout_count (timeout_count)
  );

  initial begin
    sample_clk = 1'b0;
    forever #5 sample_clk = ~sample_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  typedef struct {
    logic [7:0] byte_v;
    logic [1:0] exp_state;
    logic [7:0] exp_cmd;
    logic [7:0] exp_drop;
    logic [7:0] exp_resp;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    rx_cmd_valid = 1'b1;
    rx_cmd       = b;
    tick();
    rx_cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string name);
    int n = 0;
    while (seq_state !== target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(seq_state), 32'(target));
  endtask

  task automatic complete_response();
    wait_state(2'b10, 20, "reach_tx");
    tx_handoff = ~tx_handoff;
    tick();
    wait_state(2'b00, 20, "back_to_listen");
  endtask

  int e_resp;
  int e_drop;
  int e_to;
  int high;

  initial begin
    vecs[0] = '{8'h02, 2'b00, 8'h00, 8'd1, 8'd0};
    vecs[1] = '{8'h03, 2'b00, 8'h00, 8'd2, 8'd0};
    vecs[2] = '{8'h7F, 2'b00, 8'h00, 8'd3, 8'd0};
    vecs[3] = '{8'hFF, 2'b01, 8'hFF, 8'd3, 8'd1};
    vecs[4] = '{8'h04, 2'b00, 8'hFF, 8'd4, 8'd1};
    vecs[5] = '{8'h00, 2'b01, 8'h00, 8'd4, 8'd2};
    vecs[6] = '{8'h80, 2'b00, 8'h00, 8'd5, 8'd2};
    vecs[7] = '{8'h01, 2'b01, 8'h01, 8'd5, 8'd3};
    vecs[8] = '{8'hFE, 2'b00, 8'h01, 8'd6, 8'd3};

    reset        = 1'b1;
    rx_cmd_valid = 1'b0;
    rx_cmd       = 8'h00;
    tx_handoff   = 1'b0;
    tick();
    tick();
    check("rst_cur_op", 32'(cur_operation), 32'd0);
    check("rst_cmd", 32'(cmd), 32'h00);
    check("rst_state", 32'(seq_state), 32'd0);
    check("rst_resp", 32'(resp_count), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_timeout", 32'(timeout_count), 32'd0);
    reset = 1'b0;
    tick();

    // LISTEN command table
    for (int i = 0; i < 9; i++) begin
      pulse(vecs[i].byte_v);
      check($sformatf("vec%0d_state", i), 32'(seq_state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
      check($sformatf("vec%0d_drop", i), 32'(drop_count), 32'(vecs[i].exp_drop));
      check($sformatf("vec%0d_curop", i), 32'(cur_operation), 32'd0);
      if (vecs[i].exp_state == 2'b01) complete_response();
      check($sformatf("vec%0d_resp", i), 32'(resp_count), 32'(vecs[i].exp_resp));
    end

    // Basic timing: accept, turnaround, handoff, recover, immediate re-accept
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e_resp = 0; e_drop = 0; e_to = 0;
    tick();
    pulse(8'h01);
    check("t_state_turn", 32'(seq_state), 32'd1);
    check("t_cmd", 32'(cmd), 32'h01);
    repeat (7) tick();
    check("t_curop_before", 32'(cur_operation), 32'd0);
    tick();
    check("t_curop_rise", 32'(cur_operation), 32'd1);
    check("t_state_tx", 32'(seq_state), 32'd2);
    repeat (80) tick();
    check("t_curop_hold", 32'(cur_operation), 32'd1);
    tx_handoff = ~tx_handoff;
    tick();
    e_resp++;
    check("t_curop_fall", 32'(cur_operation), 32'd0);
    check("t_resp", 32'(resp_count), 32'(e_resp));
    check("t_state_rec", 32'(seq_state), 32'd3);
    repeat (15) tick();
    check("t_rec_last", 32'(seq_state), 32'd3);
    tick();
    check("t_listen", 32'(seq_state), 32'd0);
    pulse(8'h00);
    check("t_first_listen_accept", 32'(seq_state), 32'd1);
    complete_response();
    e_resp++;
    check("t_resp2", 32'(resp_count), 32'(e_resp));

    // Commands ignored outside LISTEN; handoff ignored in LISTEN
    pulse(8'h00);
    repeat (3) tick();
    pulse(8'h00);
    check("ign_turn_state", 32'(seq_state), 32'd1);
    pulse(8'h02);
    check("ign_turn_drop", 32'(drop_count), 32'(e_drop));
    repeat (2) tick();
    check("ign_turn_len", 32'(seq_state), 32'd1);
    tick();
    check("ign_tx_enter", 32'(seq_state), 32'd2);
    pulse(8'h01);
    check("ign_tx_state", 32'(seq_state), 32'd2);
    check("ign_tx_cmd", 32'(cmd), 32'h00);
    tx_handoff = ~tx_handoff;
    tick();
    e_resp++;
    pulse(8'h01);
    check("ign_rec_state", 32'(seq_state), 32'd3);
    repeat (14) tick();
    check("ign_rec_len", 32'(seq_state), 32'd3);
    tick();
    check("ign_rec_exit", 32'(seq_state), 32'd0);
    tx_handoff = ~tx_handoff;
    tick();
    check("ign_listen_handoff_state", 32'(seq_state), 32'd0);
    check("ign_listen_handoff_resp", 32'(resp_count), 32'(e_resp));
    pulse(8'h00);
    wait_state(2'b10, 20, "ign_reach_tx");
    repeat (5) tick();
    check("ign_no_spurious", 32'(seq_state), 32'd2);
    check("ign_resp", 32'(resp_count), 32'(e_resp));
    tx_handoff = ~tx_handoff;
    tick();
    e_resp++;
    wait_state(2'b00, 20, "ign_back_listen");

    // Handoff on the watchdog's expiry cycle wins
    pulse(8'hFF);
    wait_state(2'b10, 20, "same_reach_tx");
    repeat (511) tick();
    check("same_still_tx", 32'(seq_state), 32'd2);
    tx_handoff = ~tx_handoff;
    tick();
    e_resp++;
    check("same_state", 32'(seq_state), 32'd3);
    check("same_resp", 32'(resp_count), 32'(e_resp));
    check("same_timeout", 32'(timeout_count), 32'(e_to));
    wait_state(2'b00, 20, "same_back_listen");

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      pulse(8'h02 + 8'(i % 250));
      tick();
    end
    check("drop_sat", 32'(drop_count), 32'd255);
    check("drop_state", 32'(seq_state), 32'd0);
    check("drop_curop", 32'(cur_operation), 32'd0);
    check("drop_cmd", 32'(cmd), 32'hFF);

    // Watchdog length and timeout saturation
    for (int r = 0; r < 20; r++) begin
      pulse(8'hFF);
      wait_state(2'b10, 20, "wd_reach_tx");
      high = 0;
      while (cur_operation === 1'b1 && high < 700) begin
        high++;
        tick();
      end
      check($sformatf("wd%0d_high_cycles", r), 32'(high), 32'd512);
      e_to = (e_to < 15) ? e_to + 1 : 15;
      check($sformatf("wd%0d_timeout", r), 32'(timeout_count), 32'(e_to));
      wait_state(2'b00, 30, "wd_back_listen");
    end
    check("wd_sat", 32'(timeout_count), 32'd15);
    check("wd_resp", 32'(resp_count), 32'(e_resp));

    // Reset mid-TX with tx_handoff rising on the same edge
    tx_handoff = 1'b0;
    tick();
    pulse(8'h01);
    wait_state(2'b10, 20, "rst_reach_tx");
    reset      = 1'b1;
    tx_handoff = 1'b1;
    tick();
    check("midrst_curop", 32'(cur_operation), 32'd0);
    check("midrst_cmd", 32'(cmd), 32'h00);
    check("midrst_state", 32'(seq_state), 32'd0);
    check("midrst_resp", 32'(resp_count), 32'd0);
    check("midrst_drop", 32'(drop_count), 32'd0);
    check("midrst_timeout", 32'(timeout_count), 32'd0);
    reset = 1'b0;
    repeat (20) tick();
    check("post_rst_resp", 32'(resp_count), 32'd0);
    check("post_rst_state", 32'(seq_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
